// File: rtl/strobe_sequencer_if.sv
// strobe_sequencer_if: control, table-config and timer-side signals of the step sequencer
interface strobe_sequencer_if #(
  parameter int WIDTH  = 25,
  parameter int DEPTH  = 8,
  parameter int MASK_W = 8,
  parameter int AW     = $clog2(DEPTH)
);
  logic              start;
  logic              stop;
  logic              loop;
  logic              tick_en;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [WIDTH-1:0]  cfg_period;
  logic [MASK_W-1:0] cfg_mask;
  logic [AW:0]       cfg_len;
  logic              tmr_rst;
  logic              tmr_enable;
  logic [WIDTH-1:0]  tmr_reset_value;
  logic              tmr_strobe;
  logic              step_strobe;
  logic [AW-1:0]     step_idx;
  logic [MASK_W-1:0] out_mask;
  logic              busy;
  logic              done;
  logic              cfg_err;
  modport master (
    output start, stop, loop, tick_en, cfg_we, cfg_addr, cfg_period, cfg_mask, cfg_len, tmr_strobe,
    input  tmr_rst, tmr_enable, tmr_reset_value, step_strobe, step_idx, out_mask, busy, done, cfg_err
  );
  modport slave (
    input  start, stop, loop, tick_en, cfg_we, cfg_addr, cfg_period, cfg_mask, cfg_len, tmr_strobe,
    output tmr_rst, tmr_enable, tmr_reset_value, step_strobe, step_idx, out_mask, busy, done, cfg_err
  );
endinterface

// File: rtl/strobe_sequencer.sv
// strobe_sequencer: walks a period/mask table, driving one shared counter_with_strobe per step
module strobe_sequencer #(
  parameter int WIDTH  = 25,
  parameter int DEPTH  = 8,
  parameter int MASK_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  strobe_sequencer_if.slave bus
);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0]  per [DEPTH];
  logic [MASK_W-1:0] msk [DEPTH];
  logic [AW:0]       len, len_w, len_eff;
  logic [AW-1:0]     idx, idx_n;
  logic [WIDTH-1:0]  rv;
  logic [MASK_W-1:0] mask_q;
  logic              ss, ss_n, dn, err, busy_c, wr, go, last;
  assign busy_c  = state == LOAD || state == RUN;
  assign wr      = bus.cfg_we && !busy_c;
  assign len_w   = bus.cfg_len > LW'(DEPTH) ? LW'(DEPTH) : bus.cfg_len;
  // a write landing with start in the same cycle is seen by that start
  assign len_eff = wr ? len_w : len;
  assign go      = bus.start && !busy_c && len_eff != '0 && !bus.stop;
  assign last    = {1'b0, idx} == len - LW'(1);
  always_ff @(posedge clk) begin
    if (wr) begin
      per[bus.cfg_addr] <= bus.cfg_period;
      msk[bus.cfg_addr] <= bus.cfg_mask;
    end
  end
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ss_n    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = go ? LOAD : state;
        idx_n   = go ? '0 : idx;
      end
      LOAD: state_n = RUN;
      RUN: if (bus.tmr_strobe) begin
        ss_n    = 1'b1;
        state_n = last && !bus.loop ? DONE : LOAD;
        idx_n   = last ? (bus.loop ? '0 : idx) : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (bus.stop) begin
      state_n = IDLE;
      idx_n   = '0;
      ss_n    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      len    <= '0;
      rv     <= WIDTH'(2);
      mask_q <= '0;
      ss     <= 1'b0;
      dn     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ss    <= ss_n;
      dn    <= state == DONE && ss && !bus.stop;
      err   <= (bus.cfg_we && busy_c) || (bus.start && !busy_c && len_eff == '0 && !bus.stop);
      if (wr) len <= len_w;
      if (bus.stop) mask_q <= '0;
      else if (state == LOAD) begin
        mask_q <= msk[idx];
        rv     <= per[idx] < WIDTH'(2) ? WIDTH'(2) : per[idx];
      end
    end
  end
  assign bus.tmr_rst         = rst || bus.stop || state != RUN;
  assign bus.tmr_enable      = state == RUN && bus.tick_en && !bus.stop && !rst;
  assign bus.tmr_reset_value = rv;
  assign bus.step_strobe     = ss;
  assign bus.step_idx        = idx;
  assign bus.out_mask        = mask_q;
  assign bus.busy            = busy_c;
  assign bus.done            = dn;
  assign bus.cfg_err         = err;
endmodule

// File: tb/tb_strobe_sequencer.sv
// tb_strobe_sequencer: directed checks of the sequencer against a behavioural LATENCY=0 timer
module tb_strobe_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  strobe_sequencer_if #(.WIDTH(25), .DEPTH(8), .MASK_W(8)) bus();
  strobe_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  logic [24:0] cnt;
  logic        tstb;
  always @(posedge clk) begin
    if (bus.tmr_rst) begin
      cnt  <= '0;
      tstb <= 1'b0;
    end else begin
      tstb <= 1'b0;
      if (bus.tmr_enable) begin
        if (cnt + 25'd1 >= bus.tmr_reset_value) begin
          cnt  <= '0;
          tstb <= 1'b1;
        end else cnt <= cnt + 25'd1;
      end
    end
  end
  assign bus.tmr_strobe = tstb;
  int n_run = 0, n_fail = 0;
  int cyc, bad, toggle;
  logic prev_ss;
  int s_q[$], d_q[$];
  int m_log[64], i_log[64], b_log[64], e_log[64], r_log[64], t_log[64];
  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc1();
    if (cyc < 64) begin
      m_log[cyc] = int'(bus.out_mask);
      i_log[cyc] = int'(bus.step_idx);
      b_log[cyc] = int'(bus.busy);
      e_log[cyc] = int'(bus.cfg_err);
      r_log[cyc] = int'(bus.tmr_reset_value);
      t_log[cyc] = int'(bus.tmr_strobe);
    end
    if (bus.step_strobe) s_q.push_back(cyc);
    if (bus.done) d_q.push_back(cyc);
    if (bus.tmr_enable && !bus.busy) bad++;
    if (bus.step_strobe && prev_ss) bad++;
    prev_ss = bus.step_strobe;
    if (toggle != 0) bus.tick_en = (cyc % 2 == 0);
    @(posedge clk);
    #1;
    cyc++;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.cfg_we = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask
  task automatic clr();
    cyc = 0;
    bad = 0;
    prev_ss = 1'b0;
    s_q.delete();
    d_q.delete();
  endtask
  task automatic cfg(input int a, input int p, input int m, input int l);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 3'(a);
    bus.cfg_period = 25'(p);
    bus.cfg_mask   = 8'(m);
    bus.cfg_len    = 4'(l);
  endtask
  task automatic wr(input int a, input int p, input int m, input int l);
    cfg(a, p, m, l);
    cyc1();
  endtask
  task automatic halt();
    bus.stop = 1'b1;
    run(2);
  endtask
  task automatic chk_ss(input string tag, input int n, input int e0 = 0, input int e1 = 0,
                        input int e2 = 0, input int e3 = 0, input int e4 = 0, input int e5 = 0);
    int ev[6];
    ev = '{e0, e1, e2, e3, e4, e5};
    chk({tag, "_cnt"}, s_q.size(), n);
    for (int i = 0; i < n; i++) chk(tag, i < s_q.size() ? s_q[i] : -1, ev[i]);
  endtask
  task automatic chk_done(input string tag, input int n, input int at);
    chk({tag, "_cnt"}, d_q.size(), n);
    if (n > 0) chk(tag, d_q.size() > 0 ? d_q[0] : -1, at);
  endtask
  initial begin
    bus.start = 0; bus.stop = 0; bus.loop = 0; bus.tick_en = 1; bus.cfg_we = 0;
    bus.cfg_addr = 0; bus.cfg_period = 0; bus.cfg_mask = 0; bus.cfg_len = 0;
    toggle = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tmr_rst", int'(bus.tmr_rst), 1);
    chk("rst_tmr_en", int'(bus.tmr_enable), 0);
    chk("rst_rv", int'(bus.tmr_reset_value), 2);
    chk("rst_mask", int'(bus.out_mask), 0);
    chk("rst_idx", int'(bus.step_idx), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_flags", int'({bus.step_strobe, bus.done, bus.cfg_err}), 0);
    rst = 1'b0;
    wr(0, 5, 1, 3); wr(1, 3, 2, 3); wr(2, 4, 4, 3);
    // three steps, single pass
    clr(); bus.start = 1; run(24);
    chk_ss("t1_ss", 3, 8, 13, 19);
    chk_done("t1_done", 1, 20);
    chk("t1_m3", m_log[3], 1); chk("t1_m8", m_log[8], 1); chk("t1_m9", m_log[9], 2);
    chk("t1_m13", m_log[13], 2); chk("t1_m14", m_log[14], 4); chk("t1_m23", m_log[23], 4);
    chk("t1_idx23", i_log[23], 2); chk("t1_busy1", b_log[1], 1); chk("t1_busy23", b_log[23], 0);
    chk("t1_rv3", r_log[3], 5); chk("t1_rv10", r_log[10], 3); chk("t1_inv", bad, 0);
    // looping
    clr(); bus.loop = 1; bus.start = 1; run(40);
    chk_ss("t2_ss", 6, 8, 13, 19, 26, 31, 37);
    chk("t2_idx19", i_log[19], 0); chk("t2_m20", m_log[20], 1);
    chk_done("t2_done", 0, 0);
    halt(); bus.loop = 0;
    // stop coincident with the timer strobe
    clr(); bus.start = 1; run(7); bus.stop = 1; run(5);
    chk("t4_tstb7", t_log[7], 1); chk_ss("t4_ss", 0); chk_done("t4_done", 0, 0);
    chk("t4_m7", m_log[7], 1); chk("t4_m8", m_log[8], 0);
    chk("t4_busy8", b_log[8], 0); chk("t4_idx8", i_log[8], 0);
    clr(); bus.start = 1; run(10);
    chk_ss("t4_rerun", 1, 8); chk("t4_rm9", m_log[9], 2);
    halt();
    // write while running is rejected
    clr(); bus.start = 1; run(3); cfg(0, 9, 8'hFF, 1); run(8);
    chk("t5_err3", e_log[3], 0); chk("t5_err4", e_log[4], 1); chk("t5_err5", e_log[5], 0);
    chk_ss("t5_ss", 1, 8); chk("t5_m9", m_log[9], 2);
    halt();
    clr(); bus.start = 1; run(10);
    chk("t5_m2", m_log[2], 1); chk_ss("t5_rerun", 1, 8);
    halt();
    // len=0 written together with start
    clr(); cfg(7, 2, 0, 0); bus.start = 1; run(4);
    chk("t5_lerr1", e_log[1], 1); chk("t5_lbusy1", b_log[1], 0); chk("t5_lbusy2", b_log[2], 0);
    // tick_en toggling
    wr(0, 5, 1, 1);
    clr(); toggle = 1; bus.start = 1; run(16); toggle = 0; bus.tick_en = 1;
    chk_ss("t3_ss", 1, 12); chk_done("t3_done", 1, 13); chk("t3_inv", bad, 0);
    // period 0 clamped to 2, write lands with start
    clr(); cfg(0, 0, 3, 1); bus.loop = 1; bus.start = 1; run(12);
    chk("t6_rv2", r_log[2], 2); chk("t6_m2", m_log[2], 3); chk_ss("t6_ss", 2, 5, 9);
    halt(); bus.loop = 0;
    // cfg_len beyond DEPTH clamped
    for (int i = 0; i < 8; i++) wr(i, 2, i, 15);
    clr(); bus.start = 1; run(36);
    chk("t7_cnt", s_q.size(), 8); chk("t7_last", s_q.size() == 8 ? s_q[7] : -1, 33);
    chk_done("t7_done", 1, 34); chk("t7_idx", i_log[34], 7); chk("t7_m34", m_log[34], 7);
    // reset in the middle of RUN
    wr(0, 6, 8'h5A, 1);
    clr(); bus.start = 1; run(4);
    chk("t8_rv", r_log[3], 6);
    rst = 1'b1; run(1);
    chk("t8_busy", int'(bus.busy), 0); chk("t8_rv2", int'(bus.tmr_reset_value), 2);
    chk("t8_mask", int'(bus.out_mask), 0);
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
